ram_access_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the 32x4 single-port RAM and owns its address, data and write-enable pins. It serialises three kinds of access: single-word writes via a req/ack handshake, a whole-memory clear, and a paced auto-scan read that walks every address. Each scan read is captured into a display register that the hex-decoder stage consumes.

---
 rtl/ram_access_ctrl_pkg.sv | 24 ++
 rtl/ram_access_ctrl_pace_tick.sv | 41 ++++
 rtl/ram_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_ram_access_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_access_ctrl_pkg
// Brief   : Shared state encoding and default geometry for the RAM access
//           controller and its pacing sub-block.
// Revision: 1.0
// ============================================================================
package ram_access_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        CLEAR   = 3'd2,
        READ    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    // Default RAM geometry: 32 words of 4 bits
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 4;

endpackage : ram_access_ctrl_pkg
`default_nettype wire

// File: rtl/ram_access_ctrl_pace_tick.sv
`default_nettype none
// ============================================================================
// Module  : pace_tick
// Brief   : Free-running pace counter for the auto-scan. Counts
//           0..PACE_MAX-1 while enabled and flags the wrap cycle; held at
//           zero while disabled so a re-enable always starts a full period.
// Revision: 1.0
// ============================================================================
module pace_tick #(
    parameter int PACE_MAX = 50_000_000
) (
    input  logic clock,
    input  logic resetn,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = (PACE_MAX > 1) ? $clog2(PACE_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PACE_MAX - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Pace count: wraps at PACE_MAX-1, cleared whenever scanning is disabled
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    // Wrap cycle marks one scan step; consumed by a register downstream
    assign tick = en && (cnt == LAST);

endmodule : pace_tick
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ram_access_ctrl
// Brief   : Owns the single-port RAM pins and serialises single-word writes
//           (req/ack), a whole-memory clear and a paced auto-scan read whose
//           results are held in a display register. All outputs are
//           registered so no input reaches an output combinationally.
// Revision: 1.0
// ============================================================================
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int PACE_MAX = 50_000_000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_req,
    output logic              clr_done,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] scan_ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              wren_nxt;
    logic              step_pending;
    logic              step_tick;

    pace_tick #(
        .PACE_MAX (PACE_MAX)
    ) u_pace_tick (
        .clock  (clock),
        .resetn (resetn),
        .en     (scan_en),
        .tick   (step_tick)
    );

    // State, pointers and registered RAM-side outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            scan_ptr    <= '0;
            clr_cnt     <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            wr_ack      <= 1'b0;
            clr_done    <= 1'b0;
        end else begin
            state       <= next_state;
            scan_ptr    <= ptr_nxt;
            clr_cnt     <= clr_nxt;
            ram_address <= addr_nxt;
            ram_data    <= data_nxt;
            ram_wren    <= wren_nxt;
            wr_ack      <= (next_state == WRITE);
            clr_done    <= (state == CLEAR) && (next_state == IDLE);
        end
    end

    // Next state plus the RAM pin values that the next state will present
    always_comb begin
        next_state = state;
        ptr_nxt    = (state == CAPTURE) ? scan_ptr + ADDR_ONE : scan_ptr;
        clr_nxt    = clr_cnt;
        addr_nxt   = ptr_nxt;
        data_nxt   = '0;
        wren_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (clr_req) begin
                    next_state = CLEAR;
                end else if (wr_req) begin
                    next_state = WRITE;
                end else if (step_pending) begin
                    next_state = READ;
                end
            end
            WRITE:   next_state = IDLE;
            CLEAR:   next_state = (clr_cnt == ADDR_LAST) ? IDLE : CLEAR;
            READ:    next_state = CAPTURE;
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase

        case (next_state)
            WRITE: begin
                addr_nxt = wr_addr;
                data_nxt = wr_data;
                wren_nxt = 1'b1;
            end
            CLEAR: begin
                clr_nxt  = (state == CLEAR) ? clr_cnt + ADDR_ONE : '0;
                addr_nxt = clr_nxt;
                wren_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // At most one outstanding scan step; a new tick wins over the READ clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            step_pending <= 1'b0;
        end else if (!scan_en) begin
            step_pending <= 1'b0;
        end else if (step_tick) begin
            step_pending <= 1'b1;
        end else if (state == READ) begin
            step_pending <= 1'b0;
        end
    end

    // RAM q is valid during CAPTURE, one cycle after the READ address
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            disp_addr <= '0;
            disp_data <= '0;
        end else if (state == CAPTURE) begin
            disp_addr <= scan_ptr;
            disp_data <= ram_q;
        end
    end

    assign busy = (state != IDLE);

endmodule : ram_access_ctrl
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_access_ctrl
// Brief   : Directed self-checking bench for ram_access_ctrl with a
//           behavioural 32x4 registered RAM and PACE_MAX = 4.
// Revision: 1.0
// ============================================================================
module tb_ram_access_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       wr_req;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic       clr_req;
    logic       clr_done;
    logic       scan_en;
    logic [4:0] ram_address;
    logic [3:0] ram_data;
    logic       ram_wren;
    logic [3:0] ram_q;
    logic [4:0] disp_addr;
    logic [3:0] disp_data;
    logic       busy;

    logic [3:0] mem [32];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ram_access_ctrl #(
        .ADDR_W   (5),
        .DATA_W   (4),
        .PACE_MAX (4)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .clr_req     (clr_req),
        .clr_done    (clr_done),
        .scan_en     (scan_en),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .busy        (busy)
    );

    // Behavioural single-port RAM: registered write and registered read
    always @(posedge clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] d);
        bit acked;
        acked   = 1'b0;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 10 && !acked; i++) begin
            @(negedge clock);
            if (wr_ack) acked = 1'b1;
        end
        wr_req = 1'b0;
        if (!acked) chk("wr_timeout", 32'd0, 32'd1);
        @(negedge clock);
    endtask

    task automatic fill_all(input logic [3:0] d);
        for (int i = 0; i < 32; i++) do_write(i[4:0], d);
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bad;
        bit got_done;
        bit saw_ack;

        resetn  = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
        scan_en = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_busy",      busy,        0);
        chk("rst_wren",      ram_wren,    0);
        chk("rst_addr",      ram_address, 0);
        chk("rst_data",      ram_data,    0);
        chk("rst_ack",       wr_ack,      0);
        chk("rst_clr_done",  clr_done,    0);
        chk("rst_disp_addr", disp_addr,   0);
        chk("rst_disp_data", disp_data,   0);
        resetn = 1'b1;
        @(negedge clock);

        // Single write: A to address 3
        wr_req  = 1'b1;
        wr_addr = 5'h03;
        wr_data = 4'hA;
        @(negedge clock);
        chk("wr_ack_hi",   wr_ack,      1);
        chk("wr_wren",     ram_wren,    1);
        chk("wr_addr",     ram_address, 3);
        chk("wr_data",     ram_data,    4'hA);
        wr_req = 1'b0;
        @(negedge clock);
        chk("wr_ack_lo",   wr_ack,      0);
        chk("wr_busy_lo",  busy,        0);
        chk("wr_mem3",     mem[3],      4'hA);

        // Scan four steps; capture k lands 7 + 4k edges after enable
        scan_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 6 : 3) @(negedge clock);
            chk("scan_pre",  disp_addr, (k == 0) ? 0 : k - 1);
            @(negedge clock);
            chk("scan_post", disp_addr, k);
        end
        chk("scan_data3", disp_data, 4'hA);
        scan_en = 1'b0;

        // Fill with F, then clear: busy exactly 32 cycles, then clr_done
        do_reset();
        fill_all(4'hF);
        clr_req = 1'b1;
        @(negedge clock);
        clr_req = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clock);
        end
        chk("clr_busy_cycles", cnt,      32);
        chk("clr_done_hi",     clr_done, 1);
        @(negedge clock);
        chk("clr_done_lo",     clr_done, 0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== 4'h0) bad++;
        chk("clr_mem_nonzero", bad, 0);

        // Scan all 32 words and one more to see the pointer wrap
        scan_en = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            repeat ((k == 0) ? 7 : 4) @(negedge clock);
            chk("clr_scan_addr", disp_addr, k % 32);
            chk("clr_scan_data", disp_data, 0);
        end

        // Pause for 10 cycles, then resume from where the scan stopped
        scan_en = 1'b0;
        repeat (10) @(negedge clock);
        chk("pause_hold", disp_addr, 0);
        scan_en = 1'b1;
        repeat (6) @(negedge clock);
        chk("resume_pre",  disp_addr, 0);
        @(negedge clock);
        chk("resume_addr", disp_addr, 1);
        chk("resume_data", disp_data, 0);
        scan_en = 1'b0;
        @(negedge clock);

        // Simultaneous write and clear: clear wins, write follows
        wr_req  = 1'b1;
        wr_addr = 5'h07;
        wr_data = 4'h5;
        clr_req = 1'b1;
        @(negedge clock);
        chk("coll_busy",   busy,   1);
        chk("coll_no_ack", wr_ack, 0);
        clr_req  = 1'b0;
        got_done = 1'b0;
        saw_ack  = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            @(negedge clock);
            if (wr_ack)   saw_ack  = 1'b1;
            if (clr_done) got_done = 1'b1;
        end
        chk("coll_clr_done",     got_done, 1);
        chk("coll_ack_in_clear", saw_ack,  0);
        cnt = 0;
        while (!wr_ack && cnt < 3) begin
            cnt++;
            @(negedge clock);
        end
        chk("coll_ack_delay", cnt,         1);
        chk("coll_wr_addr",   ram_address, 7);
        wr_req = 1'b0;
        @(negedge clock);
        chk("coll_mem7",      mem[7],      4'h5);

        // Reset during cycle 10 of a clear
        fill_all(4'hF);
        clr_req = 1'b1;
        @(negedge clock);
        clr_req = 1'b0;
        repeat (10) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        chk("abort_busy",     busy,        0);
        chk("abort_wren",     ram_wren,    0);
        chk("abort_addr",     ram_address, 0);
        chk("abort_clr_done", clr_done,    0);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < 10 && mem[i] !== 4'h0) bad++;
            if (i >= 10 && mem[i] !== 4'hF) bad++;
        end
        chk("abort_mem", bad, 0);
        resetn   = 1'b1;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (clr_done) got_done = 1'b1;
        end
        chk("abort_no_done", got_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ram_access_ctrl
`default_nettype wire
